// File: rtl/mem_stage.sv
// MEM stage of the 5-stage CPU: word load/store over the shared bus via a
// req/grant/strobe/ready handshake, misalignment detection and the MEM/WB register.
module mem_stage #(
   parameter int WORD_ADDR_W = 30,
   parameter int DATA_W      = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int EXP_W       = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   flush,
   output logic                   busy,
   input  logic [WORD_ADDR_W-1:0] ex_pc,
   input  logic                   ex_en,
   input  logic                   ex_br_flag,
   input  logic [1:0]             ex_ctrl_op,
   input  logic [REG_ADDR_W-1:0]  ex_dst_addr,
   input  logic                   ex_gpr_we_,
   input  logic [EXP_W-1:0]       ex_exp_code,
   input  logic [1:0]             ex_mem_op,
   input  logic [DATA_W-1:0]      ex_mem_wr_data,
   input  logic [DATA_W-1:0]      ex_out,
   output logic                   bus_req,
   input  logic                   bus_grnt,
   output logic                   bus_as,
   output logic                   bus_rw,
   output logic [WORD_ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0]      bus_wr_data,
   input  logic [DATA_W-1:0]      bus_rd_data,
   input  logic                   bus_rdy,
   output logic [WORD_ADDR_W-1:0] mem_pc,
   output logic                   mem_en,
   output logic                   mem_br_flag,
   output logic [1:0]             mem_ctrl_op,
   output logic [REG_ADDR_W-1:0]  mem_dst_addr,
   output logic                   mem_gpr_we_,
   output logic [EXP_W-1:0]       mem_exp_code,
   output logic [DATA_W-1:0]      mem_out
);

   localparam logic [1:0]       MEM_OP_NOP     = 2'd0;
   localparam logic [1:0]       MEM_OP_LDW     = 2'd1;
   localparam logic [1:0]       MEM_OP_STW     = 2'd2;
   localparam logic [1:0]       CTRL_OP_NOP    = 2'd0;
   localparam logic [EXP_W-1:0] EXP_NO         = '0;
   localparam logic [EXP_W-1:0] EXP_MISS_ALIGN = EXP_W'(4);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACCESS, ST_STALL} state_t;

   state_t                 state_q, state_d;
   logic [DATA_W-1:0]      rd_buf_q, rd_buf_d;
   logic                   mem_valid, misalign, access, from_buf, wb_load;

   logic [WORD_ADDR_W-1:0] mem_pc_q, mem_pc_d;
   logic                   mem_en_q, mem_en_d;
   logic                   mem_br_flag_q, mem_br_flag_d;
   logic [1:0]             mem_ctrl_op_q, mem_ctrl_op_d;
   logic [REG_ADDR_W-1:0]  mem_dst_addr_q, mem_dst_addr_d;
   logic                   mem_gpr_we_q, mem_gpr_we_d;
   logic [EXP_W-1:0]       mem_exp_code_q, mem_exp_code_d;
   logic [DATA_W-1:0]      mem_out_q, mem_out_d;

   always_comb begin : fsm_comb
      mem_valid = ex_en & (ex_mem_op != MEM_OP_NOP);
      misalign  = mem_valid & (ex_out[1:0] != 2'b00);
      access    = mem_valid & (ex_out[1:0] == 2'b00) & (ex_exp_code == EXP_NO) & ~flush;

      state_d  = state_q;
      rd_buf_d = rd_buf_q;
      busy     = 1'b0;
      bus_req  = 1'b0;
      bus_as   = 1'b0;
      from_buf = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (access) begin
               bus_req = 1'b1;
               busy    = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            bus_req = 1'b1;
            busy    = 1'b1;
            if (flush)         state_d = ST_IDLE;
            else if (bus_grnt) state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // A started transfer always completes; flush only acts on the MEM/WB load.
            bus_req = 1'b1;
            bus_as  = 1'b1;
            if (bus_rdy) begin
               rd_buf_d = bus_rd_data;
               state_d  = stall ? ST_STALL : ST_IDLE;
            end else begin
               busy = 1'b1;
            end
         end
         ST_STALL: begin
            from_buf = 1'b1;
            if (!stall) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Keep the bus quiet while reset is held, even if EX presents a valid access.
      if (reset) begin
         busy    = 1'b0;
         bus_req = 1'b0;
         bus_as  = 1'b0;
      end

      bus_rw      = bus_req & (ex_mem_op == MEM_OP_LDW);
      bus_addr    = bus_req ? ex_out[WORD_ADDR_W+1:2] : '0;
      bus_wr_data = bus_req ? ex_mem_wr_data : '0;
   end

   always_comb begin : wb_comb
      wb_load        = ~stall & ~busy;
      mem_pc_d       = mem_pc_q;
      mem_en_d       = mem_en_q;
      mem_br_flag_d  = mem_br_flag_q;
      mem_ctrl_op_d  = mem_ctrl_op_q;
      mem_dst_addr_d = mem_dst_addr_q;
      mem_gpr_we_d   = mem_gpr_we_q;
      mem_exp_code_d = mem_exp_code_q;
      mem_out_d      = mem_out_q;

      if (wb_load) begin
         if (flush) begin
            mem_pc_d       = '0;
            mem_en_d       = 1'b0;
            mem_br_flag_d  = 1'b0;
            mem_ctrl_op_d  = CTRL_OP_NOP;
            mem_dst_addr_d = '0;
            mem_gpr_we_d   = 1'b1;
            mem_exp_code_d = EXP_NO;
            mem_out_d      = '0;
         end else if (misalign) begin
            mem_pc_d       = ex_pc;
            mem_en_d       = ex_en;
            mem_br_flag_d  = ex_br_flag;
            mem_ctrl_op_d  = CTRL_OP_NOP;
            mem_dst_addr_d = '0;
            mem_gpr_we_d   = 1'b1;
            mem_exp_code_d = EXP_MISS_ALIGN;
            mem_out_d      = '0;
         end else begin
            mem_pc_d       = ex_pc;
            mem_en_d       = ex_en;
            mem_br_flag_d  = ex_br_flag;
            mem_ctrl_op_d  = ex_ctrl_op;
            mem_dst_addr_d = ex_dst_addr;
            mem_gpr_we_d   = ex_gpr_we_;
            mem_exp_code_d = ex_exp_code;
            if (ex_exp_code != EXP_NO)
               mem_out_d = ex_out;
            else if (ex_en && ex_mem_op == MEM_OP_LDW)
               mem_out_d = from_buf ? rd_buf_q : bus_rd_data;
            else if (ex_en && ex_mem_op == MEM_OP_STW)
               mem_out_d = '0;
            else
               mem_out_d = ex_out;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         rd_buf_q       <= '0;
         mem_pc_q       <= '0;
         mem_en_q       <= 1'b0;
         mem_br_flag_q  <= 1'b0;
         mem_ctrl_op_q  <= CTRL_OP_NOP;
         mem_dst_addr_q <= '0;
         mem_gpr_we_q   <= 1'b1;
         mem_exp_code_q <= EXP_NO;
         mem_out_q      <= '0;
      end else begin
         state_q        <= state_d;
         rd_buf_q       <= rd_buf_d;
         mem_pc_q       <= mem_pc_d;
         mem_en_q       <= mem_en_d;
         mem_br_flag_q  <= mem_br_flag_d;
         mem_ctrl_op_q  <= mem_ctrl_op_d;
         mem_dst_addr_q <= mem_dst_addr_d;
         mem_gpr_we_q   <= mem_gpr_we_d;
         mem_exp_code_q <= mem_exp_code_d;
         mem_out_q      <= mem_out_d;
      end
   end

   assign mem_pc       = mem_pc_q;
   assign mem_en       = mem_en_q;
   assign mem_br_flag  = mem_br_flag_q;
   assign mem_ctrl_op  = mem_ctrl_op_q;
   assign mem_dst_addr = mem_dst_addr_q;
   assign mem_gpr_we_  = mem_gpr_we_q;
   assign mem_exp_code = mem_exp_code_q;
   assign mem_out      = mem_out_q;

endmodule
